// File: rtl/xts_sector_sequencer.sv
// ---------------------------------------------------------------------------
// xts_sector_sequencer
//
// Control sequencer for an XTS-AES sector engine. It sequences the key
// scheduler (key1 then key2), the tweak encryptor, and the per-block data
// engine. It also handles the input/output data handshakes and the
// tweak-times-alpha updates between blocks. Every engine handshake is
// guarded by a timeout.
//
// Parameters
//   BLOCK_CNT_W  width of the sector block count and of the block index
//   TIMEOUT      maximum number of cycles spent waiting on an engine
//
// Ports
//   inClk, inRst          clock, synchronous active-high reset
//   inKeyWr               pulse: a new key1/key2 pair has been written
//   inSectorStart         pulse: process one sector
//   inBlockCount          number of 128-bit blocks (sampled with start)
//   inDecrypt             direction, 1 = decrypt (sampled with start)
//   inKeySchBusy          key scheduler busy
//   inAesEncBusy          tweak encryptor busy
//   inAesEncDecBusy       data engine busy
//   inDataValid           an input data block is available
//   inOutReady            downstream accepts the output block
//   outKeySchStart        pulse: start the key scheduler
//   outKeySel             key select for the scheduler (0 key1, 1 key2)
//   outTweakEncStart      pulse: start the tweak encryption
//   outDataEncDecStart    pulse: start the data engine
//   outDataRd             pulse: consume the input data block
//   outDataOutWr          level: the output block is valid
//   outTweakUpdate        pulse: multiply the tweak by alpha
//   outBlockIdx           index of the current block
//   outDecrypt            latched direction
//   outBusy               level: a key schedule or sector is in progress
//   outKeysValid          level: both round-key sets are ready
//   outSectorDone         pulse: the sector has completed
//   outError              pulse: timeout or illegal request
// ---------------------------------------------------------------------------
module xts_sector_sequencer #(
  parameter int unsigned BLOCK_CNT_W = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   inClk,
  input  logic                   inRst,
  input  logic                   inKeyWr,
  input  logic                   inSectorStart,
  input  logic [BLOCK_CNT_W-1:0] inBlockCount,
  input  logic                   inDecrypt,
  input  logic                   inKeySchBusy,
  input  logic                   inAesEncBusy,
  input  logic                   inAesEncDecBusy,
  input  logic                   inDataValid,
  input  logic                   inOutReady,
  output logic                   outKeySchStart,
  output logic                   outKeySel,
  output logic                   outTweakEncStart,
  output logic                   outDataEncDecStart,
  output logic                   outDataRd,
  output logic                   outDataOutWr,
  output logic                   outTweakUpdate,
  output logic [BLOCK_CNT_W-1:0] outBlockIdx,
  output logic                   outDecrypt,
  output logic                   outBusy,
  output logic                   outKeysValid,
  output logic                   outSectorDone,
  output logic                   outError
);

  typedef enum logic [3:0] {
    IDLE,
    KS1_START,
    KS1_WAIT,
    KS2_START,
    KS2_WAIT,
    TWK_START,
    TWK_WAIT,
    BLK_DATA,
    BLK_START,
    BLK_WAIT,
    BLK_OUT,
    DONE
  } state_t;

  // The wait counter only has to reach TIMEOUT-1; the timeout fires on that value.
  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t                 state;
  logic [WAIT_W-1:0]      waitCnt;
  logic                   seenBusy;
  logic [BLOCK_CNT_W-1:0] blockCnt;
  logic                   engBusy;

  // Busy flag of the engine that the current wait state is watching.
  always_comb begin
    engBusy = 1'b0;
    case (state)
      KS1_WAIT, KS2_WAIT: engBusy = inKeySchBusy;
      TWK_WAIT:           engBusy = inAesEncBusy;
      BLK_WAIT:           engBusy = inAesEncDecBusy;
      default:            engBusy = 1'b0;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state              <= IDLE;
      waitCnt            <= '0;
      seenBusy           <= 1'b0;
      blockCnt           <= '0;
      outKeySchStart     <= 1'b0;
      outKeySel          <= 1'b0;
      outTweakEncStart   <= 1'b0;
      outDataEncDecStart <= 1'b0;
      outDataRd          <= 1'b0;
      outDataOutWr       <= 1'b0;
      outTweakUpdate     <= 1'b0;
      outBlockIdx        <= '0;
      outDecrypt         <= 1'b0;
      outBusy            <= 1'b0;
      outKeysValid       <= 1'b0;
      outSectorDone      <= 1'b0;
      outError           <= 1'b0;
    end else begin
      outKeySchStart     <= 1'b0;
      outTweakEncStart   <= 1'b0;
      outDataEncDecStart <= 1'b0;
      outDataRd          <= 1'b0;
      outTweakUpdate     <= 1'b0;
      outSectorDone      <= 1'b0;
      outError           <= 1'b0;

      // Requests that arrive during an operation are rejected.
      // They do not disturb the sequence in progress.
      if (outBusy && (inKeyWr || inSectorStart)) begin
        outError <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (inKeyWr) begin
            // A key write takes precedence; a simultaneous sector start is dropped.
            outKeysValid   <= 1'b0;
            outKeySel      <= 1'b0;
            outKeySchStart <= 1'b1;
            outBusy        <= 1'b1;
            state          <= KS1_START;
          end else if (inSectorStart) begin
            if (outKeysValid && (inBlockCount != '0)) begin
              blockCnt         <= inBlockCount;
              outDecrypt       <= inDecrypt;
              outBlockIdx      <= '0;
              outTweakEncStart <= 1'b1;
              outBusy          <= 1'b1;
              state            <= TWK_START;
            end else begin
              outError <= 1'b1;
            end
          end
        end

        KS1_START, KS2_START, TWK_START, BLK_START: begin
          waitCnt  <= '0;
          seenBusy <= 1'b0;
          case (state)
            KS1_START: state <= KS1_WAIT;
            KS2_START: state <= KS2_WAIT;
            TWK_START: state <= TWK_WAIT;
            default:   state <= BLK_WAIT;
          endcase
        end

        KS1_WAIT, KS2_WAIT, TWK_WAIT, BLK_WAIT: begin
          if (engBusy) begin
            seenBusy <= 1'b1;
          end
          if (seenBusy && !engBusy) begin
            case (state)
              KS1_WAIT: begin
                outKeySel      <= 1'b1;
                outKeySchStart <= 1'b1;
                state          <= KS2_START;
              end
              KS2_WAIT: begin
                outKeysValid <= 1'b1;
                outBusy      <= 1'b0;
                state        <= IDLE;
              end
              TWK_WAIT: begin
                state <= BLK_DATA;
              end
              default: begin
                outDataOutWr <= 1'b1;
                state        <= BLK_OUT;
              end
            endcase
          end else if (waitCnt == WAIT_LAST) begin
            outError     <= 1'b1;
            outKeysValid <= 1'b0;
            outBusy      <= 1'b0;
            state        <= IDLE;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end

        BLK_DATA: begin
          if (inDataValid) begin
            outDataRd          <= 1'b1;
            outDataEncDecStart <= 1'b1;
            state              <= BLK_START;
          end
        end

        BLK_OUT: begin
          if (inOutReady) begin
            outDataOutWr <= 1'b0;
            // Comparing against count-1 ensures the last block never advances the index.
            // So the index cannot wrap, even for a count of all ones.
            if (outBlockIdx == blockCnt - BLOCK_CNT_W'(1)) begin
              outSectorDone <= 1'b1;
              state         <= DONE;
            end else begin
              outTweakUpdate <= 1'b1;
              outBlockIdx    <= outBlockIdx + BLOCK_CNT_W'(1);
              state          <= BLK_DATA;
            end
          end
        end

        DONE: begin
          outBusy <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          outBusy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/xts_sector_sequencer.md
XTS_SECTOR_SEQUENCER -- requirements
Module: xts_sector_sequencer

Interface
REQ-001 Parameter BLOCK_CNT_W, default 8, SHALL set the width of the sector block count and block index.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles to wait on any engine handshake.
REQ-003 inClk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 inRst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 inKeyWr  in  1  SHALL be a one-cycle pulse: a new key1/key2 pair is in the key register.
REQ-006 inSectorStart  in  1  SHALL be a one-cycle pulse requesting processing of one sector.
REQ-007 inBlockCount  in  BLOCK_CNT_W  SHALL give the number of 128-bit blocks in the sector, sampled with inSectorStart.
REQ-008 inDecrypt  in  1  SHALL select decryption (1) or encryption (0), sampled with inSectorStart.
REQ-009 inKeySchBusy, inAesEncBusy, inAesEncDecBusy  in  1 each  SHALL be the busy flags of the key scheduler, tweak encryptor and data engine.
REQ-010 inDataValid  in  1  SHALL indicate an input data block is available; inOutReady  in  1  SHALL indicate the downstream accepts output.
REQ-011 outKeySchStart  out  1  SHALL be a start pulse; outKeySel  out  1  SHALL select key1 (0) or key2 (1) for the scheduler.
REQ-012 outTweakEncStart, outDataEncDecStart  out  1 each  SHALL be start pulses; outDataRd  out  1  SHALL be the input-consume pulse.
REQ-013 outDataOutWr  out  1  SHALL be the output-valid level; outTweakUpdate  out  1  SHALL be the tweak-times-alpha pulse.
REQ-014 outBlockIdx  out  BLOCK_CNT_W  SHALL be the current block index; outDecrypt  out  1  SHALL be the latched direction.
REQ-015 outBusy, outKeysValid  out  1 each  SHALL be status levels; outSectorDone, outError  out  1 each  SHALL be one-cycle pulses.

Function
REQ-016 FSM states SHALL be IDLE, KS1_START, KS1_WAIT, KS2_START, KS2_WAIT, TWK_START, TWK_WAIT, BLK_DATA, BLK_START, BLK_WAIT, BLK_OUT, DONE; outBusy SHALL be 1 in every state except IDLE.
REQ-017 IDLE + inKeyWr SHALL clear outKeysValid and enter KS1_START; outKeySchStart SHALL be asserted for exactly the next cycle, with outKeySel=0.
REQ-018 Each *_START state SHALL last one cycle, assert its start pulse, and go to the matching *_WAIT state.
REQ-019 A *_WAIT state SHALL set a seen-busy flag when the engine busy flag is 1 and SHALL exit on the first cycle with busy=0 after seen-busy was set.
REQ-020 A *_WAIT state SHALL count cycles; reaching TIMEOUT SHALL pulse outError, clear outKeysValid and return to IDLE.
REQ-021 KS1_WAIT exit SHALL go to KS2_START (outKeySel=1); KS2_WAIT exit SHALL set outKeysValid=1 and return to IDLE.
REQ-022 IDLE + inSectorStart with outKeysValid=1 and inBlockCount!=0 SHALL latch count and direction, clear outBlockIdx, and enter TWK_START.
REQ-023 inSectorStart with outKeysValid=0 or inBlockCount=0 SHALL pulse outError and stay in IDLE.
REQ-024 inKeyWr and inSectorStart in the same IDLE cycle: inKeyWr SHALL win; inSectorStart SHALL be dropped without error.
REQ-025 inKeyWr or inSectorStart while outBusy=1 SHALL be ignored and SHALL pulse outError; the FSM SHALL be unaffected.
REQ-026 TWK_WAIT exit SHALL go to BLK_DATA; BLK_DATA SHALL wait for inDataValid=1, then go to BLK_START.
REQ-027 In BLK_START, outDataRd and outDataEncDecStart SHALL pulse together for one cycle; BLK_WAIT SHALL follow.
REQ-028 BLK_OUT SHALL hold outDataOutWr=1 until inOutReady=1; transfer SHALL occur in the cycle both are 1.
REQ-029 On transfer when outBlockIdx != count-1: pulse outTweakUpdate, increment outBlockIdx, go to BLK_DATA.
REQ-030 On transfer when outBlockIdx == count-1: no outTweakUpdate; go to DONE, which SHALL pulse outSectorDone for one cycle and return to IDLE with outBlockIdx unchanged.
REQ-031 Count 2^BLOCK_CNT_W-1 SHALL process all blocks; outBlockIdx SHALL never wrap.

Reset
REQ-032 inRst=1 SHALL force IDLE, clear all counters and flags, and drive every output to 0, taking priority over all other inputs, including in the middle of a sector or key schedule.

Verification
REQ-033 Reset, then inKeyWr; scheduler busy for 10 cycles in each run -> two outKeySchStart pulses (outKeySel 0 then 1), then outKeysValid=1 and outBusy=0.
REQ-034 Keys valid, inSectorStart with count=3, data always valid, ready always 1 -> 1 outTweakEncStart, 3 outDataRd/outDataEncDecStart, 2 outTweakUpdate, 1 outSectorDone; outBlockIdx steps 0,1,2.
REQ-035 inSectorStart with outKeysValid=0, and a separate inSectorStart with count=0 -> outError pulse each time; outBusy stays 0.
REQ-036 inAesEncBusy held 0 after outTweakEncStart -> outError after 255 cycles; IDLE; outKeysValid=0.
REQ-037 inOutReady=0 for 5 cycles in BLK_OUT -> outDataOutWr held 5 cycles, no tweak update until accept.
REQ-038 inRst asserted in BLK_WAIT -> next cycle all outputs 0, IDLE; a following inSectorStart gives outError.
